// File: rtl/stswi_debounce.sv
// stswi_debounce
// Conditions the raw slide-switch bits ahead of the half-subtractor datapath.
// Each bit is synchronised through a two-flop chain and then debounced by its
// own counter. A debounced bit flips only after its synchronised input has
// differed from it for DB_CYCLES consecutive clock edges.
//
// Ports:
//   clk_50mhz  - system clock; all state updates on its rising edge
//   rst_n      - asynchronous active-low reset; clears all state
//   stswi_raw  - raw asynchronous switch levels (WIDTH bits)
//   stswi_db   - debounced switch levels; bit 0 = operand A, bit 1 = operand B
//   chg_stb    - per-bit one-cycle strobe, high in the cycle stswi_db[i] changes
//   any_chg    - OR of chg_stb, registered one cycle later (display refresh)
module stswi_debounce #(
  parameter int WIDTH     = 2,
  parameter int DB_CYCLES = 500000
) (
  input  logic             clk_50mhz,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] stswi_raw,
  output logic [WIDTH-1:0] stswi_db,
  output logic [WIDTH-1:0] chg_stb,
  output logic             any_chg
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Two-flop synchroniser; nothing may be placed between the stages.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= stswi_raw;
      sync2 <= sync1;
    end
  end

  // One fully independent debounce channel per switch bit.
  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
        cnt         <= '0;
        stswi_db[g] <= 1'b0;
        chg_stb[g]  <= 1'b0;
      end else if (sync2[g] == stswi_db[g]) begin
        // Any matching cycle discards a partial count.
        cnt        <= '0;
        chg_stb[g] <= 1'b0;
      end else if (cnt == CNT_LAST) begin
        // DB_CYCLES-th consecutive mismatch: accept the new level.
        stswi_db[g] <= sync2[g];
        cnt         <= '0;
        chg_stb[g]  <= 1'b1;
      end else begin
        cnt        <= cnt + 1'b1;
        chg_stb[g] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      any_chg <= 1'b0;
    end else begin
      any_chg <= |chg_stb;
    end
  end

endmodule

// File: tb/tb_stswi_debounce.sv
// Directed bench for stswi_debounce with WIDTH=2, DB_CYCLES=4.
// Each table row gives rst_n and stswi_raw applied before a rising edge and
// the expected {stswi_db, chg_stb, any_chg} just after that edge.
module tb_stswi_debounce;

  logic       clk_50mhz;
  logic       rst_n;
  logic [1:0] stswi_raw;
  logic [1:0] stswi_db;
  logic [1:0] chg_stb;
  logic       any_chg;

  int errors;
  int checks;

  stswi_debounce #(
    .WIDTH    (2),
    .DB_CYCLES(4)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .rst_n    (rst_n),
    .stswi_raw(stswi_raw),
    .stswi_db (stswi_db),
    .chg_stb  (chg_stb),
    .any_chg  (any_chg)
  );

  initial clk_50mhz = 1'b0;
  always #5 clk_50mhz = ~clk_50mhz;

  typedef struct {
    logic       rst;
    logic [1:0] raw;
    logic [1:0] db;
    logic [1:0] stb;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  task automatic push(input int n, input logic rst, input logic [1:0] raw,
                      input logic [1:0] db, input logic [1:0] stb, input logic any);
    vec_t v;
    v.rst = rst; v.raw = raw; v.db = db; v.stb = stb; v.any = any;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] db, input logic [1:0] stb,
                     input logic any);
    checks++;
    if ({stswi_db, chg_stb, any_chg} !== {db, stb, any}) begin
      errors++;
      $display("FAIL %s: got db=%b stb=%b any=%b, required db=%b stb=%b any=%b",
               name, stswi_db, chg_stb, any_chg, db, stb, any);
    end
  endtask

  // Drive inputs at the falling edge, sample 1 ns after the rising edge.
  task automatic tick(input logic rst, input logic [1:0] raw);
    @(negedge clk_50mhz);
    rst_n     = rst;
    stswi_raw = raw;
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic run(input string name, input int n, input logic rst, input logic [1:0] raw,
                     input logic [1:0] db, input logic [1:0] stb, input logic any);
    for (int k = 0; k < n; k++) begin
      tick(rst, raw);
      chk(name, db, stb, any);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    stswi_raw = 2'b11;

    // Reset held with switches high, then acquisition after release.
    push(2, 0, 2'b11, 2'b00, 2'b00, 0);
    push(5, 1, 2'b11, 2'b00, 2'b00, 0);
    push(1, 1, 2'b11, 2'b11, 2'b11, 0);
    push(1, 1, 2'b11, 2'b11, 2'b00, 1);
    push(1, 1, 2'b11, 2'b11, 2'b00, 0);
    // Both back to 0.
    push(5, 1, 2'b00, 2'b11, 2'b00, 0);
    push(1, 1, 2'b00, 2'b00, 2'b11, 0);
    push(1, 1, 2'b00, 2'b00, 2'b00, 1);
    push(1, 1, 2'b00, 2'b00, 2'b00, 0);
    // Clean toggle of bit 0.
    push(5, 1, 2'b01, 2'b00, 2'b00, 0);
    push(1, 1, 2'b01, 2'b01, 2'b01, 0);
    push(1, 1, 2'b01, 2'b01, 2'b00, 1);
    push(1, 1, 2'b01, 2'b01, 2'b00, 0);
    // Glitches on bit 1 reaching count DB_CYCLES-1, then a held high level.
    push(3, 1, 2'b11, 2'b01, 2'b00, 0);
    push(1, 1, 2'b01, 2'b01, 2'b00, 0);
    push(3, 1, 2'b11, 2'b01, 2'b00, 0);
    push(1, 1, 2'b01, 2'b01, 2'b00, 0);
    push(5, 1, 2'b11, 2'b01, 2'b00, 0);
    push(1, 1, 2'b11, 2'b11, 2'b10, 0);
    push(1, 1, 2'b11, 2'b11, 2'b00, 1);
    push(1, 1, 2'b11, 2'b11, 2'b00, 0);
    // Simultaneous change of both bits.
    push(5, 1, 2'b00, 2'b11, 2'b00, 0);
    push(1, 1, 2'b00, 2'b00, 2'b11, 0);
    push(1, 1, 2'b00, 2'b00, 2'b00, 1);
    push(1, 1, 2'b00, 2'b00, 2'b00, 0);
    // Back-to-back: bit 0 up, held 6 edges, then down.
    push(5, 1, 2'b01, 2'b00, 2'b00, 0);
    push(1, 1, 2'b01, 2'b01, 2'b01, 0);
    push(1, 1, 2'b00, 2'b01, 2'b00, 1);
    push(4, 1, 2'b00, 2'b01, 2'b00, 0);
    push(1, 1, 2'b00, 2'b00, 2'b01, 0);
    push(1, 1, 2'b00, 2'b00, 2'b00, 1);
    push(1, 1, 2'b00, 2'b00, 2'b00, 0);

    #1;
    chk("reset_initial", 2'b00, 2'b00, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].raw);
      chk($sformatf("vec%0d", i), tbl[i].db, tbl[i].stb, tbl[i].any);
    end

    // Reset while a strobe is high kills it without a clock edge.
    run("stb_pre", 5, 1, 2'b10, 2'b00, 2'b00, 0);
    run("stb_flip", 1, 1, 2'b10, 2'b10, 2'b10, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_kill_stb", 2'b00, 2'b00, 0);
    run("rst_hold", 2, 0, 2'b11, 2'b00, 2'b00, 0);
    run("reacq_wait", 5, 1, 2'b11, 2'b00, 2'b00, 0);
    run("reacq_flip", 1, 1, 2'b11, 2'b11, 2'b11, 0);
    run("reacq_any", 1, 1, 2'b11, 2'b11, 2'b00, 1);

    // Reset mid-count: bit 1 falls, reset after 3 edges, count is abandoned.
    run("mid_count", 3, 1, 2'b01, 2'b11, 2'b00, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_drop", 2'b00, 2'b00, 0);
    run("mid_rst_hold", 1, 0, 2'b01, 2'b00, 2'b00, 0);
    run("post_rel_wait", 5, 1, 2'b01, 2'b00, 2'b00, 0);
    run("post_rel_flip", 1, 1, 2'b01, 2'b01, 2'b01, 0);
    run("post_rel_any", 1, 1, 2'b01, 2'b01, 2'b00, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
